scan_sequencer: RTL and testbench

Upstream feeder for the address calculator: a scan walks sub-table index `j` from 0 to a programmed last value, pairing each `j` with one encoded query value `x_enc` taken from an input stream. It emits one `(i, j, x_enc)` triple per handshake. The address calculator turns each triple combinationally into `bram_number` and `bram_address`. The block owns scan start/stop, back-pressure and completion signalling for one query.

---
 rtl/mithril_pkg.sv | 15 +
 rtl/scan_out_reg.sv | 46 ++++
 rtl/scan_sequencer.sv | 118 +++++++++++
 tb/tb_scan_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mithril_pkg.sv
// Shared definitions for the scan sequencer and the address calculator:
// default field widths and the scan FSM state encoding.
package mithril_pkg;

    localparam int unsigned ISizeDefault = 1;
    localparam int unsigned JSizeDefault = 9;
    localparam int unsigned XSizeDefault = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } scan_state_e;

endpackage

// File: rtl/scan_out_reg.sv
// Single-entry valid/ready output register holding one {i, j, x_enc, last} triple.
// A new load may replace the entry in the same cycle the current one is accepted.
module scan_out_reg #(
    parameter int unsigned I_SIZE = 1,
    parameter int unsigned J_SIZE = 9,
    parameter int unsigned X_SIZE = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              load,
    input  logic [I_SIZE-1:0] i_d,
    input  logic [J_SIZE-1:0] j_d,
    input  logic [X_SIZE-1:0] x_d,
    input  logic              last_d,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [I_SIZE-1:0] i,
    output logic [J_SIZE-1:0] j,
    output logic [X_SIZE-1:0] x_enc,
    output logic              out_last
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            i         <= '0;
            j         <= '0;
            x_enc     <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_last  <= last_d;
            i         <= i_d;
            j         <= j_d;
            x_enc     <= x_d;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// Scan sequencer: walks j from 0 to j_last, pairing each j with one x_enc from the input stream.
// Optional stall counter output enabled by defining SCAN_SEQUENCER_STALL_CNT_EN.
module scan_sequencer
    import mithril_pkg::*;
#(
    parameter int unsigned I_SIZE = ISizeDefault,
    parameter int unsigned J_SIZE = JSizeDefault,
    parameter int unsigned X_SIZE = XSizeDefault
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [I_SIZE-1:0] i_in,
    input  logic [J_SIZE-1:0] j_last,
    input  logic              abort,
    input  logic              x_valid,
    input  logic [X_SIZE-1:0] x_enc_in,
    output logic              x_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [I_SIZE-1:0] i,
    output logic [J_SIZE-1:0] j,
    output logic [X_SIZE-1:0] x_enc,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef SCAN_SEQUENCER_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    scan_state_e       state;
    logic [I_SIZE-1:0] i_q;
    logic [J_SIZE-1:0] j_last_q;
    logic [J_SIZE-1:0] j_cnt;
    logic              in_hs;
    logic              at_last;

    assign x_ready = (state == StRun) && (!out_valid || out_ready);
    assign in_hs   = x_valid && x_ready;
    assign at_last = (j_cnt == j_last_q);
    assign busy    = (state != StIdle);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= StIdle;
            i_q      <= '0;
            j_last_q <= '0;
            j_cnt    <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= StIdle;
            end else begin
                case (state)
                    StIdle: begin
                        if (start) begin
                            i_q      <= i_in;
                            j_last_q <= j_last;
                            j_cnt    <= '0;
                            state    <= StRun;
                        end
                    end
                    StRun: begin
                        // j_cnt stops at j_last so a full 2^J_SIZE sweep never wraps
                        if (in_hs) begin
                            if (at_last) state <= StDrain;
                            else         j_cnt <= j_cnt + J_SIZE'(1);
                        end
                    end
                    StDrain: begin
                        if (out_valid && out_ready) begin
                            state <= StIdle;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    scan_out_reg #(
        .I_SIZE (I_SIZE),
        .J_SIZE (J_SIZE),
        .X_SIZE (X_SIZE)
    ) u_out_reg (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (abort),
        .load      (in_hs),
        .i_d       (i_q),
        .j_d       (j_cnt),
        .x_d       (x_enc_in),
        .last_d    (at_last),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .i         (i),
        .j         (j),
        .x_enc     (x_enc),
        .out_last  (out_last)
    );

`ifdef SCAN_SEQUENCER_STALL_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (state == StIdle && start && !abort) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: expected triples are queued per scan, a monitor checks them.
module tb_scan_sequencer;

    localparam int IS = 1;
    localparam int JS = 9;
    localparam int XS = 3;

    logic          clock, reset_n, start, abort, x_valid, x_ready;
    logic          out_valid, out_ready, out_last, busy, done;
    logic [IS-1:0] i_in, o_i;
    logic [JS-1:0] j_last, o_j;
    logic [XS-1:0] x_enc_in, o_x;
`ifdef SCAN_SEQUENCER_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    scan_sequencer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .i_in      (i_in),
        .j_last    (j_last),
        .abort     (abort),
        .x_valid   (x_valid),
        .x_enc_in  (x_enc_in),
        .x_ready   (x_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .i         (o_i),
        .j         (o_j),
        .x_enc     (o_x),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
`ifdef SCAN_SEQUENCER_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    typedef struct {
        int i;
        int j;
        int x;
        bit last;
    } trip_t;

    trip_t exp_q[$];
    int    x_stream[$];
    int    basic_x[5] = '{3, 1, 7, 0, 5};
    int    n_vec = 0;
    int    n_err = 0;
    int    cycle_no = 0;
    int    t0 = 0;
    int    stall_model = 0;
    bit    exp_done = 0;
    bit    hold_prev = 0;
    int    prev_i, prev_j, prev_x, prev_last;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cycle_no <= cycle_no + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_stall();
`ifdef SCAN_SEQUENCER_STALL_CNT_EN
        check("stall_cnt", int'(stall_cnt), stall_model);
`endif
    endtask

    task automatic chk_zero();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_x_ready", int'(x_ready), 0);
        check("rst_i", int'(o_i), 0);
        check("rst_j", int'(o_j), 0);
        check("rst_x_enc", int'(o_x), 0);
        stall_model = 0;
        chk_stall();
    endtask

    // Reference model: one triple per j in 0..l, last only at j == l.
    task automatic push_scan(input int l, input int iv, input bit fixed);
        for (int k = 0; k <= l; k++) begin
            int xv;
            xv = fixed ? basic_x[k] : int'($urandom_range(0, 7));
            x_stream.push_back(xv);
            exp_q.push_back('{iv, k, xv, (k == l)});
        end
    endtask

    // Monitor: pops expected triples on every output handshake, checks protocol rules.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                check("done", int'(done), int'(exp_done));
                exp_done = 0;
                if (out_valid && !out_ready) begin
                    stall_model++;
                    check("x_ready_blocked", int'(x_ready), 0);
                end
                if (hold_prev) begin
                    check("hold_valid", int'(out_valid), 1);
                    check("hold_i", int'(o_i), prev_i);
                    check("hold_j", int'(o_j), prev_j);
                    check("hold_x", int'(o_x), prev_x);
                    check("hold_last", int'(out_last), prev_last);
                end
                if (out_valid && out_ready && !abort) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_triple_j", int'(o_j), -1);
                    end else begin
                        trip_t e;
                        e = exp_q.pop_front();
                        check("trip_i", int'(o_i), e.i);
                        check("trip_j", int'(o_j), e.j);
                        check("trip_x", int'(o_x), e.x);
                        check("trip_last", int'(out_last), int'(e.last));
                        exp_done = e.last;
                    end
                end
                hold_prev = out_valid && !out_ready && !abort;
                prev_i    = int'(o_i);
                prev_j    = int'(o_j);
                prev_x    = int'(o_x);
                prev_last = int'(out_last);
            end
        end
    end

    // Called at posedge+1 in IDLE; leaves the bench at posedge+1 of the first RUN cycle.
    task automatic do_start(input int l, input int iv, input bit fixed);
        start  = 1'b1;
        i_in   = IS'(iv);
        j_last = JS'(l);
        push_scan(l, iv, fixed);
        stall_model = 0;
        @(posedge clock);
        #1;
        start = 1'b0;
        t0 = cycle_no;
    endtask

    task automatic stream(input int xv_pct, input int rdy_pct, input int stall_first,
                          input int abort_after, input int busy_after, input int b2b_l,
                          input int lat_exp);
        int hs = 0;
        int cyc = 0;
        int stall_left = stall_first;
        bit busy_used = 0;
        bit b2b_used = 0;
        bit xr_chk = 1;
        bit fin = 0;
        while (!fin) begin
            start = 1'b0;
            if (abort_after >= 0 && hs == abort_after + 1) begin
                abort     = 1'b1;
                out_ready = 1'b0;
                x_valid   = 1'b0;
                @(posedge clock);
                #1;
                abort = 1'b0;
                check("abort_out_valid", int'(out_valid), 0);
                check("abort_out_last", int'(out_last), 0);
                check("abort_busy", int'(busy), 0);
                check("abort_x_ready", int'(x_ready), 0);
                exp_q.delete();
                x_stream.delete();
                repeat (3) begin
                    @(posedge clock);
                    #1;
                end
                return;
            end
            x_valid  = (x_stream.size() > 0) && ($urandom_range(0, 99) < xv_pct);
            x_enc_in = (x_stream.size() > 0) ? XS'(x_stream[0]) : '0;
            if (stall_left > 0 && hs > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = ($urandom_range(0, 99) < rdy_pct);
            end
            if (busy_after >= 0 && hs == busy_after && !busy_used) begin
                start     = 1'b1;
                i_in      = IS'(0);
                j_last    = JS'(1);
                busy_used = 1;
            end
            @(negedge clock);
            if (xr_chk) begin
                check("x_ready_after_start", int'(x_ready), 1);
                xr_chk = 0;
            end
            if (x_valid && x_ready) begin
                void'(x_stream.pop_front());
                hs++;
            end
            if (done) begin
                if (lat_exp > 0 && !b2b_used) check("start_to_done", cycle_no - t0, lat_exp);
                check("all_delivered", exp_q.size(), 0);
                chk_stall();
                if (b2b_l >= 0 && !b2b_used) begin
                    start  = 1'b1;
                    i_in   = IS'(0);
                    j_last = JS'(b2b_l);
                    push_scan(b2b_l, 0, 0);
                    stall_model = 0;
                    b2b_used = 1;
                    xr_chk = 1;
                    hs = 0;
                end else begin
                    fin = 1;
                end
            end
            cyc++;
            if (cyc > 5000) begin
                check("scan_timeout", cyc, 0);
                fin = 1;
            end
            @(posedge clock);
            #1;
        end
        start   = 1'b0;
        x_valid = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        x_valid   = 1'b0;
        out_ready = 1'b0;
        i_in      = '0;
        j_last    = '0;
        x_enc_in  = '0;
        repeat (2) @(posedge clock);
        #1;
        chk_zero();
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Basic scan with the fixed x sequence
        do_start(4, 1, 1);
        stream(100, 100, 0, -1, -1, -1, 6);
        // Back-pressure right after the first output
        do_start(2, 0, 0);
        stream(100, 100, 3, -1, -1, -1, 0);
        // Edge scans: single entry, then full sweep
        do_start(0, 1, 0);
        stream(100, 100, 0, -1, -1, -1, 2);
        do_start(511, 0, 0);
        stream(80, 75, 0, -1, -1, -1, 0);
        // Abort at j = 3, then a clean scan
        do_start(7, 1, 0);
        stream(100, 100, 0, 3, -1, -1, 0);
        do_start(5, 0, 0);
        stream(90, 90, 0, -1, -1, -1, 0);
        // Ignored start during RUN, then back-to-back start in the done cycle
        do_start(6, 1, 0);
        stream(90, 80, 0, -1, 2, 3, 0);
        // Random scans
        for (int n = 0; n < 6; n++) begin
            do_start(int'($urandom_range(0, 20)), int'($urandom_range(0, 1)), 0);
            stream(70, 70, 0, -1, -1, -1, 0);
        end

        // Reset mid-DRAIN
        do_start(3, 1, 0);
        for (int k = 0; k < 4; k++) begin
            x_valid   = 1'b1;
            x_enc_in  = XS'(x_stream.pop_front());
            out_ready = 1'b1;
            @(posedge clock);
            #1;
        end
        x_valid   = 1'b0;
        out_ready = 1'b0;
        check("drain_busy", int'(busy), 1);
        check("drain_out_valid", int'(out_valid), 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk_zero();
        exp_q.delete();
        x_stream.delete();
        exp_done  = 0;
        hold_prev = 0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        do_start(1, 1, 0);
        stream(100, 100, 0, -1, -1, -1, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
